// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache between the fetch
// port and the memory controller. Hits are combinational. A miss fetches one
// word over iREN/iwait and fills the frame; the hit is then served from the array.
// Latency: hit 0 cycles; miss 1 (detect) + N (memory) + 1 (hit from array).
// Backpressure: one miss at a time; the fill always completes once started, and
//   iwait=1 holds the FILL state.
// Ports: CLK, RST (sync, active-high); imemREN/imemaddr -> ihit/imemload (fetch
//   side); iREN/iaddr -> iwait/iload (memory side).
// Build option: ICACHE_STATS_EN adds the hit_count/miss_count outputs.
module icache_direct #(
  parameter int  SETS  = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        data_q [SETS];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic               hit;
  logic               fill_we;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr_q[IDX_W+1:2];
  assign miss_tag = miss_addr_q[31:IDX_W+2];

  assign hit      = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign imemload = data_q[req_idx];
  // The miss address register is zero after reset, so iaddr reads 0 then.
  assign iaddr    = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    iREN        = 1'b0;
    fill_we     = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = hit;
        if (imemREN && !hit) begin
          miss_addr_d = imemaddr;
          state_d     = FILL;
        end
      end
      FILL: begin
        iREN = 1'b1;
        // The fill is never aborted: the requester's inputs are ignored here.
        if (!iwait) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_we) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag/data arrays are not reset; a fill that coincides with reset is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && fill_we) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (state_q == IDLE && ihit)                hit_count_q  <= hit_count_q + 32'd1;
      if (state_q == IDLE && state_d == FILL)     miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed bench for icache_direct (SETS=16).
// Inputs change 1ns after the rising edge; outputs are sampled 4ns after it.
// Expected hit data is queued when a request is issued and popped on ihit.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  icache_direct dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Serve a fill already in progress: nwait busy cycles, then one data cycle.
  task automatic fill_cycles(input string nm, input logic [31:0] a, input int nwait,
                             input logic [31:0] d);
    for (int i = 0; i <= nwait; i++) begin
      iwait = (i < nwait);
      iload = (i < nwait) ? 32'h0 : d;
      #3;
      chk({nm, "_iren"}, 32'(iREN), 32'd1);
      chk({nm, "_iaddr"}, iaddr, a);
      chk({nm, "_nohit"}, 32'(ihit), 32'd0);
      tick();
    end
    iwait = 1'b1;
    iload = 32'h0;
  endtask

  // Wait (bounded) for ihit, check the wait length and the queued data.
  task automatic wait_hit(input string nm, input int exp_wait);
    int n;
    logic [31:0] e;
    n = 0;
    #3;
    while (!ihit && n < 8) begin
      tick();
      #3;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(exp_wait));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
    chk({nm, "_data"}, imemload, e);
    chk({nm, "_iren0"}, 32'(iREN), 32'd0);
  endtask

  task automatic miss_now(input string nm);
    #3;
    chk({nm, "_miss"}, 32'(ihit), 32'd0);
    chk({nm, "_iren0"}, 32'(iREN), 32'd0);
    tick();
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    tick();
    tick();
    RST = 1'b0;
    #3;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_hitcnt", hit_count, 32'd0);
    chk("rst_misscnt", miss_count, 32'd0);
`endif
    tick();

    // Cold miss on 0x40: 3 busy cycles, data, then hit in cycle 5.
    imemREN = 1'b1; imemaddr = 32'h40;
    exp_q.push_back(32'h3C010005);
    miss_now("cold");
    fill_cycles("cold", 32'h40, 3, 32'h3C010005);
    wait_hit("cold", 0);
    tick();

    // Warm hits: the same request held for 3 more cycles.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'h3C010005);
      wait_hit("warm", 0);
      tick();
    end

    // No request: no hit, no memory read, even for a cached address.
    imemREN = 1'b0;
    #3;
    chk("idle_ihit", 32'(ihit), 32'd0);
    chk("idle_iren", 32'(iREN), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("stat_hitcnt", hit_count, 32'd4);
    chk("stat_misscnt", miss_count, 32'd1);
`endif
    tick();

    // Conflict: 0x80 shares index 0 with 0x40 and evicts it.
    imemREN = 1'b1; imemaddr = 32'h80;
    exp_q.push_back(32'hA5A50080);
    miss_now("conf80");
    fill_cycles("conf80", 32'h80, 1, 32'hA5A50080);
    wait_hit("conf80", 0);
    tick();
    imemaddr = 32'h40;
    exp_q.push_back(32'h3C010005);
    miss_now("evict40");
    fill_cycles("evict40", 32'h40, 0, 32'h3C010005);
    wait_hit("evict40", 0);
    tick();

    // Address change mid-fill: 0x44 completes, then 0x48 misses, 0x44 hits.
    imemaddr = 32'h44;
    miss_now("mid44");
    imemaddr = 32'h48;
    fill_cycles("mid44", 32'h44, 2, 32'h00440044);
    exp_q.push_back(32'h00480048);
    miss_now("mid48");
    fill_cycles("mid48", 32'h48, 0, 32'h00480048);
    wait_hit("mid48", 0);
    tick();
    imemaddr = 32'h44;
    exp_q.push_back(32'h00440044);
    wait_hit("hit44", 0);
    tick();

    // Reset coinciding with the fill data cycle for 0x50: nothing is written.
    imemaddr = 32'h50;
    miss_now("rfill");
    iwait = 1'b1;
    #3;
    chk("rfill_busy_iren", 32'(iREN), 32'd1);
    tick();
    iwait = 1'b0; iload = 32'hDEADBEEF; RST = 1'b1;
    #3;
    chk("rfill_last_iren", 32'(iREN), 32'd1);
    tick();
    RST = 1'b0; iwait = 1'b1; iload = 32'h0; imemREN = 1'b0;
    #3;
    chk("rfill_iren", 32'(iREN), 32'd0);
    chk("rfill_iaddr", iaddr, 32'h0);
    chk("rfill_ihit", 32'(ihit), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rfill_hitcnt", hit_count, 32'd0);
    chk("rfill_misscnt", miss_count, 32'd0);
`endif
    tick();
    imemREN = 1'b1; imemaddr = 32'h50;
    exp_q.push_back(32'h11112222);
    miss_now("re50");
    fill_cycles("re50", 32'h50, 0, 32'h11112222);
    wait_hit("re50", 0);
    tick();
    imemaddr = 32'h40;
    exp_q.push_back(32'h3C010005);
    miss_now("re40");
    fill_cycles("re40", 32'h40, 0, 32'h3C010005);
    wait_hit("re40", 0);
    tick();
`ifdef ICACHE_STATS_EN
    imemREN = 1'b0;
    #3;
    chk("end_hitcnt", hit_count, 32'd2);
    chk("end_misscnt", miss_count, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
